// File: rtl/int16_stream_accum_pkg.sv
// Shared types and helpers for the INT16 stream accumulator: FSM state,
// signed range limits for an arbitrary accumulator width, and input sign extension.
package int16_accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam int unsigned IN_W_DEF  = 16;
  localparam int unsigned ACC_W_DEF = 32;
  localparam int unsigned CNT_W_DEF = 16;

  // Largest signed value representable in w bits, returned 64-bit wide.
  function automatic logic signed [63:0] acc_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] acc_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Sign-extend the low w bits of d to 64 bits.
  function automatic logic signed [63:0] sext_in(input logic [63:0] d, input int unsigned w);
    logic [63:0] m;
    m = '1 << w;
    return d[w - 1] ? (d | m) : (d & ~m);
  endfunction

endpackage

// File: rtl/int16_stream_accum_sat_add.sv
// Combinational saturating signed adder: exact sum in W+1 bits, clamped to
// the W-bit signed range with an overflow indication.
module sat_add_s
  import int16_accum_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_ovf
);

  localparam logic [W-1:0] SAT_MAX = W'(acc_max(W));
  localparam logic [W-1:0] SAT_MIN = W'(acc_min(W));

  logic [W:0] w_exact;

  assign w_exact = {i_a[W-1], i_a} + {i_b[W-1], i_b};
  // Top two bits disagree exactly when the true sum leaves the W-bit range.
  assign o_ovf   = w_exact[W] ^ w_exact[W-1];
  assign o_sum   = o_ovf ? (w_exact[W] ? SAT_MIN : SAT_MAX) : w_exact[W-1:0];

endmodule

// File: rtl/int16_stream_accum.sv
// Accumulates vectors of signed INT16 cast results into a saturating sum and
// presents sum, beat count and sticky sat/NV flags on a valid/ready output.
module int16_stream_accum
  import int16_accum_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_nv,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat,
  output logic             out_nv
);

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sat;
  logic               r_nv;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [ACC_W-1:0]   r_out_sum;
  logic [CNT_W-1:0]   r_out_count;
  logic               r_out_sat;
  logic               r_out_nv;

  logic [ACC_W-1:0]   w_ext;
  logic [ACC_W-1:0]   w_sum;
  logic               w_ovf;
  logic [CNT_W-1:0]   w_cnt_next;

  assign w_ext      = ACC_W'(sext_in(64'(in_data), IN_W));
  assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  sat_add_s #(.W(ACC_W)) u_sat_add (
    .i_a   (r_acc),
    .i_b   (w_ext),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sat       <= 1'b0;
      r_nv        <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_sat   <= 1'b0;
      r_out_nv    <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (in_valid) begin
            if (in_last) begin
              // Result includes the last beat; running state restarts for the next vector.
              r_out_sum   <= w_sum;
              r_out_count <= w_cnt_next;
              r_out_sat   <= r_sat | w_ovf;
              r_out_nv    <= r_nv | in_nv;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_sat       <= 1'b0;
              r_nv        <= 1'b0;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_acc <= w_sum;
              r_cnt <= w_cnt_next;
              r_sat <= r_sat | w_ovf;
              r_nv  <= r_nv | in_nv;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ACCUM;
          end
        end
        default: begin
          r_state     <= ACCUM;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;
  assign out_sat   = r_out_sat;
  assign out_nv    = r_out_nv;

endmodule
